ifetch_bp: RTL and testbench
============================

// Module: ifetch_bp
// PURPOSE
//  Parametrised instruction fetch unit with an instruction queue and a 2-bit BHT branch predictor.
//  Sits between the I-cache and the decoder; conditional branches are predicted instead of stalling fetch.
//  JALR still stops fetch until the ROB redirects.
//  ROB mispredict or redirect flushes the queue and the in-flight request.
// PARAMETERS
//  IQ_DEPTH_LOG  3        log2 of instruction queue depth (8 entries)
//  BHT_IDX_W     6        BHT index width (64 entries), indexed by pc[BHT_IDX_W+1:2]
//  RESET_PC      32'h0    fetch start address after reset
// PORTS
//  clk          in   1   clock; single clock domain
//  rst          in   1   synchronous active-high reset
//  rdy          in   1   global enable; low = every register holds
//  pc_cache     out  32  fetch address to I-cache
//  pc_flag      out  1   fetch request valid; the I-cache accepts it in the same cycle
//  ins_ori      in   32  instruction returned by the I-cache
//  ins_ori_flag in   1   ins_ori valid; exactly one per accepted request; latency >= 1 cycle
//  ins          out  32  queue-head instruction
//  ins_pc       out  32  queue-head PC
//  ins_pred     out  1   queue-head predicted-taken; 1 for JAL, 0 for non-branches
//  ins_flag     out  1   queue head valid
//  lsb_full     in   1   backpressure
//  rob_full     in   1   backpressure
//  rs_full      in   1   backpressure
//  br_commit    in   1   ROB retires a conditional branch
//  br_pc        in   32  PC of the retiring branch
//  br_taken     in   1   actual outcome of the retiring branch
//  jp_wrong     in   1   redirect: mispredicted branch or any JALR
//  jp_target    in   32  absolute redirect PC
// BEHAVIOUR
//  Reset values
//   - pc_cache=RESET_PC; queue empty, so ins_flag=0.
//   - State=REQ; every BHT entry=2'b01 (weakly not-taken).
//  Handshakes
//   - Pop: ins_flag && !(lsb_full|rob_full|rs_full). ins/ins_pc/ins_pred are combinational from the head.
//   - Request: pc_flag = rdy && state==REQ && !full && !jp_wrong.
//   - At most one request is outstanding.
//  FSM
//   - REQ: request accepted -> WAIT.
//   - WAIT, on ins_ori_flag: push {ins_ori, pc_cache, pred}, then compute the next PC by opcode:
//       JAL: pc + J-imm, pred=1, -> REQ.
//       BRANCH: BHT[pc][1] ? pc+B-imm : pc+4; pred=BHT[pc][1]; -> REQ.
//       JALR: pushed, pc unchanged, -> HALT.
//       Other opcodes: pc+4, -> REQ.
//   - HALT: no requests until jp_wrong.
//   - DROP: the next ins_ori_flag is discarded, then -> REQ.
//  Immediates
//   - Sign-extended to 32 bits; bit 0 is zero; PC add wraps modulo 2^32.
//  Flush (jp_wrong, highest priority)
//   - Queue cleared (a same-cycle pop is ignored); pc_cache<=jp_target.
//   - WAIT without a same-cycle response -> DROP.
//   - WAIT with a same-cycle response: response dropped, -> REQ.
//   - REQ/HALT/DROP -> REQ (DROP keeps DROP if its response is still pending).
//  BHT update
//   - On br_commit: 2-bit saturating inc/dec at br_pc index.
//   - A prediction read of the same entry in the same cycle sees the old value.
//  Queue
//   - Circular pointers wrap at 2^IQ_DEPTH_LOG.
//   - Push and pop in the same cycle keep the count; full blocks requests only.
//   - A response always has room: the request was issued only when not full.
//  Enable and reset priority
//   - rdy=0 freezes state, queue, BHT and pc; pc_flag=0.
//   - rst mid-operation: a late cache response is ignored because state=REQ.
// TESTING
//  1. Reset, 4 ADDI responses at latency 2 -> pc_cache 0,4,8,C; ins_pc order 0,4,8,C; ins_flag after first response.
//  2. BEQ at 0x10, imm +0x20, BHT reset -> pred=0, next fetch 0x14; after 2 br_commit taken -> same BEQ predicts 0x30, pred=1.
//  3. JAL at 0x40, imm -0x40 -> next pc_cache 0x0, ins_pred=1; JALR -> pc_flag stays 0 until jp_wrong, target 0x100.
//  4. Hold rob_full high, feed 8 ADDIs -> queue full, pc_flag=0; release -> one pop per cycle, fetch resumes.
//  5. jp_wrong target 0x200 while WAIT, stale response 2 cycles later -> dropped, no push, next request 0x200.
//  6. jp_wrong same cycle as ins_ori_flag and a pop -> queue empty next cycle, pc_cache=target; rdy=0 for 3 cycles -> no state change.

Source files
------------

// File: rtl/ifetch_bp.sv
// ifetch_bp -- instruction fetch unit with an instruction queue and a 2-bit BHT.
//
// Fetches one instruction at a time from the I-cache. Responses are pushed into
// a circular queue that feeds the decoder. Conditional branches are predicted
// with a table of 2-bit saturating counters, so fetch never stalls on them.
// A JALR parks fetch until the ROB redirects.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   rdy            global enable; when low every register holds
//   pc_cache       fetch address to the I-cache (registered)
//   pc_flag        fetch request valid; the cache accepts it in the same cycle
//   ins_ori        instruction returned by the cache
//   ins_ori_flag   ins_ori valid (one per accepted request)
//   ins, ins_pc    queue-head instruction and its PC
//   ins_pred       queue-head predicted-taken bit
//   ins_flag       queue head valid
//   lsb_full, rob_full, rs_full   downstream backpressure (any one blocks pop)
//   br_commit, br_pc, br_taken    retiring conditional branch, trains the BHT
//   jp_wrong, jp_target           redirect: flush everything, fetch from target
module ifetch_bp #(
    parameter int          IQ_DEPTH_LOG = 3,
    parameter int          BHT_IDX_W    = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic [31:0] pc_cache,
    output logic        pc_flag,
    input  logic [31:0] ins_ori,
    input  logic        ins_ori_flag,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_pred,
    output logic        ins_flag,
    input  logic        lsb_full,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        br_commit,
    input  logic [31:0] br_pc,
    input  logic        br_taken,
    input  logic        jp_wrong,
    input  logic [31:0] jp_target
);

    localparam int IQ_DEPTH  = 1 << IQ_DEPTH_LOG;
    localparam int BHT_DEPTH = 1 << BHT_IDX_W;
    localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE  = IQ_DEPTH_LOG'(1);
    localparam logic [IQ_DEPTH_LOG:0]   CNT_ONE  = (IQ_DEPTH_LOG+1)'(1);
    localparam logic [IQ_DEPTH_LOG:0]   CNT_FULL = (IQ_DEPTH_LOG+1)'(IQ_DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // free to issue a request
        S_WAIT = 2'd1,   // one request outstanding, response will be used
        S_HALT = 2'd2,   // JALR fetched, wait for a redirect
        S_DROP = 2'd3    // one request outstanding, response must be discarded
    } state_t;

    // J-type immediate, sign-extended, bit 0 forced to zero
    function automatic logic [31:0] j_imm(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended, bit 0 forced to zero
    function automatic logic [31:0] b_imm(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    // 2-bit saturating counter step
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != 2'b11) r = c + 2'b01;
            else            r = c;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
            else            r = c;
        end
        return r;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [31:0]             pc_r;
    logic [31:0]             pc_nxt_s;
    logic [IQ_DEPTH_LOG-1:0] head_r;
    logic [IQ_DEPTH_LOG-1:0] tail_r;
    logic [IQ_DEPTH_LOG:0]   count_r;
    logic [31:0]             q_ins_r  [IQ_DEPTH];
    logic [31:0]             q_pc_r   [IQ_DEPTH];
    logic                    q_pred_r [IQ_DEPTH];
    logic [1:0]              bht_r    [BHT_DEPTH];

    logic                    full_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    push_pred_s;
    logic                    bht_pred_s;
    logic [BHT_IDX_W-1:0]    pred_idx_s;
    logic [BHT_IDX_W-1:0]    upd_idx_s;
    logic                    unused_s;

    assign pred_idx_s = pc_r[BHT_IDX_W+1:2];
    assign upd_idx_s  = br_pc[BHT_IDX_W+1:2];
    assign bht_pred_s = bht_r[pred_idx_s][1];
    assign unused_s   = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};

    assign full_s   = (count_r == CNT_FULL);
    assign ins_flag = (count_r != '0);
    assign pop_s    = ins_flag && !(lsb_full || rob_full || rs_full);
    assign pc_flag  = rdy && (state_r == S_REQ) && !full_s && !jp_wrong;
    assign pc_cache = pc_r;
    assign ins      = q_ins_r[head_r];
    assign ins_pc   = q_pc_r[head_r];
    assign ins_pred = q_pred_r[head_r];

    // Next-state, next-PC and push decision
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        push_s      = 1'b0;
        push_pred_s = 1'b0;
        if (jp_wrong) begin
            pc_nxt_s = jp_target;
            // an outstanding request still owes a response; if it is not
            // arriving right now it has to be swallowed later in DROP
            case (state_r)
                S_WAIT, S_DROP: state_nxt_s = ins_ori_flag ? S_REQ : S_DROP;
                default:        state_nxt_s = S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (pc_flag) state_nxt_s = S_WAIT;
                    else         state_nxt_s = S_REQ;
                end
                S_WAIT: begin
                    if (ins_ori_flag) begin
                        push_s = 1'b1;
                        case (ins_ori[6:0])
                            OP_JAL: begin
                                push_pred_s = 1'b1;
                                pc_nxt_s    = pc_r + j_imm(ins_ori);
                                state_nxt_s = S_REQ;
                            end
                            OP_BRANCH: begin
                                push_pred_s = bht_pred_s;
                                if (bht_pred_s) pc_nxt_s = pc_r + b_imm(ins_ori);
                                else            pc_nxt_s = pc_r + 32'd4;
                                state_nxt_s = S_REQ;
                            end
                            OP_JALR: begin
                                state_nxt_s = S_HALT;
                            end
                            default: begin
                                pc_nxt_s    = pc_r + 32'd4;
                                state_nxt_s = S_REQ;
                            end
                        endcase
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end
                S_HALT: state_nxt_s = S_HALT;
                S_DROP: begin
                    if (ins_ori_flag) state_nxt_s = S_REQ;
                    else              state_nxt_s = S_DROP;
                end
                default: state_nxt_s = S_REQ;
            endcase
        end
    end

    // FSM state and fetch PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_REQ;
            pc_r    <= RESET_PC;
        end else if (rdy) begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Queue pointers and occupancy; a flush wins over push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (rdy) begin
            if (jp_wrong) begin
                head_r  <= '0;
                tail_r  <= '0;
                count_r <= '0;
            end else begin
                if (push_s) tail_r <= tail_r + PTR_ONE;
                if (pop_s)  head_r <= head_r + PTR_ONE;
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Queue storage; the pushed PC is the address the request was issued at
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                q_ins_r[i]  <= 32'h0;
                q_pc_r[i]   <= 32'h0;
                q_pred_r[i] <= 1'b0;
            end
        end else if (rdy && push_s) begin
            q_ins_r[tail_r]  <= ins_ori;
            q_pc_r[tail_r]   <= pc_r;
            q_pred_r[tail_r] <= push_pred_s;
        end
    end

    // BHT training; a same-cycle prediction read sees the pre-update value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (rdy && br_commit) begin
            bht_r[upd_idx_s] <= ctr_step(bht_r[upd_idx_s], br_taken);
        end
    end

endmodule

// File: tb/tb_ifetch_bp.sv
// tb_ifetch_bp -- self-checking bench for ifetch_bp.
// A behavioural model (outstanding/discard/halted flags, a queue of entries and
// a counter table) predicts the outputs every cycle; a small cache model answers
// requests with a configurable latency. Directed scenarios pin literal values,
// then a randomized phase exercises everything together.
module tb_ifetch_bp;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, pc_flag, ins_ori_flag, ins_pred, ins_flag;
    logic        lsb_full, rob_full, rs_full, br_commit, br_taken, jp_wrong;
    logic [31:0] pc_cache, ins_ori, ins, ins_pc, br_pc, jp_target;

    ifetch_bp #(.IQ_DEPTH_LOG(3), .BHT_IDX_W(6), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_cache(pc_cache), .pc_flag(pc_flag),
        .ins_ori(ins_ori), .ins_ori_flag(ins_ori_flag),
        .ins(ins), .ins_pc(ins_pc), .ins_pred(ins_pred), .ins_flag(ins_flag),
        .lsb_full(lsb_full), .rob_full(rob_full), .rs_full(rs_full),
        .br_commit(br_commit), .br_pc(br_pc), .br_taken(br_taken),
        .jp_wrong(jp_wrong), .jp_target(jp_target)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit checks_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] w; logic [31:0] pc; logic pred; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_out, m_disc, m_halt;
    logic [1:0]  m_bht [64];
    bit          e_flag;

    // ---------------- cache model and stimulus ----------------
    typedef struct { int due; logic [31:0] w; } resp_t;
    resp_t       cq[$];
    int          last_due = 0;
    int          lat_lo = 2, lat_hi = 2;
    bit          use_prog = 1'b1;
    logic [31:0] prog [logic [31:0]];

    bit          s_rst, s_rdy, s_lsb, s_rob, s_rs, s_br, s_brt, s_jp;
    logic [31:0] s_brpc, s_jpt;
    bit          arm6 = 1'b0, fired6 = 1'b0;

    logic [31:0] req_log[$];
    logic [31:0] pop_pc_log[$];
    logic        pop_pred_log[$];

    function automatic logic [31:0] rand_ins();
        int          r;
        logic [31:0] x;
        r = $urandom_range(0, 19);
        x = $urandom();
        if (r < 9)       x[6:0] = 7'b0010011;
        else if (r < 14) x[6:0] = 7'b1100011;
        else if (r < 16) x[6:0] = 7'b1101111;
        else if (r == 16) x[6:0] = 7'b1100111;
        return x;
    endfunction

    function automatic logic [31:0] prog_ins(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        return 32'h00100093;   // addi x1, x0, 1
    endfunction

    // Advance the model by one clock using the inputs driven this cycle
    task automatic model_step();
        logic [31:0] w, nxt;
        logic        pred;
        int          off;
        logic [5:0]  ui;
        if (rst) begin
            m_pc = 32'h0; m_q.delete(); m_out = 0; m_disc = 0; m_halt = 0;
            for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
            return;
        end
        if (!rdy) return;
        if (jp_wrong) begin
            m_q.delete();
            m_pc   = jp_target;
            m_halt = 0;
            if (m_out) begin
                if (ins_ori_flag) begin m_out = 0; m_disc = 0; end
                else m_disc = 1;
            end
        end else begin
            if (m_q.size() > 0 && !(lsb_full || rob_full || rs_full)) m_q.delete(0);
            if (ins_ori_flag && m_out) begin
                if (m_disc) begin
                    m_out = 0; m_disc = 0;
                end else begin
                    w = ins_ori; pred = 1'b0; nxt = m_pc + 32'd4;
                    if (w[6:0] == 7'b1101111) begin
                        off = int'({w[31], w[19:12], w[20], w[30:21], 1'b0});
                        if (w[31]) off = off - (1 << 21);
                        pred = 1'b1; nxt = m_pc + 32'(off);
                    end else if (w[6:0] == 7'b1100011) begin
                        off = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
                        if (w[31]) off = off - (1 << 13);
                        pred = m_bht[m_pc[7:2]][1];
                        if (pred) nxt = m_pc + 32'(off);
                    end else if (w[6:0] == 7'b1100111) begin
                        nxt = m_pc; m_halt = 1;
                    end
                    m_q.push_back('{w, m_pc, pred});
                    m_pc  = nxt;
                    m_out = 0;
                end
            end
            if (e_flag) m_out = 1;
        end
        if (br_commit) begin
            ui = br_pc[7:2];
            if (br_taken && m_bht[ui] < 2'd3) m_bht[ui] = m_bht[ui] + 2'd1;
            else if (!br_taken && m_bht[ui] > 2'd0) m_bht[ui] = m_bht[ui] - 2'd1;
        end
    endtask

    // One clock: drive at negedge, compare, then update cache and model at posedge
    task automatic cycle();
        bit          deliver, bp, acc;
        logic [31:0] acc_pc;
        int          d;
        @(negedge clk);
        rst = s_rst; rdy = s_rdy; lsb_full = s_lsb; rob_full = s_rob; rs_full = s_rs;
        br_commit = s_br; br_pc = s_brpc; br_taken = s_brt;
        bp = s_lsb || s_rob || s_rs;
        deliver = s_rdy && (cq.size() > 0) && (cq[0].due <= cyc);
        ins_ori_flag = deliver;
        ins_ori = deliver ? cq[0].w : $urandom();
        jp_wrong = s_jp; jp_target = s_jpt;
        if (arm6 && deliver && m_q.size() > 0 && !bp && !s_rst) begin
            jp_wrong = 1'b1; jp_target = 32'h400; arm6 = 0; fired6 = 1;
        end
        #1;
        e_flag = rdy && !m_out && !m_halt && (m_q.size() < DEPTH) && !jp_wrong;
        if (checks_on) begin
            chk("pc_flag",  32'(pc_flag),  32'(e_flag));
            chk("pc_cache", pc_cache,      m_pc);
            chk("ins_flag", 32'(ins_flag), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("ins",      ins,           m_q[0].w);
                chk("ins_pc",   ins_pc,        m_q[0].pc);
                chk("ins_pred", 32'(ins_pred), 32'(m_q[0].pred));
            end
        end
        if (rdy && !rst && !jp_wrong && m_q.size() > 0 && !bp) begin
            pop_pc_log.push_back(ins_pc);
            pop_pred_log.push_back(ins_pred);
        end
        acc = (pc_flag === 1'b1);
        acc_pc = pc_cache;
        if (acc) req_log.push_back(acc_pc);
        @(posedge clk);
        if (deliver) cq.delete(0);
        if (acc) begin
            d = cyc + $urandom_range(lat_lo, lat_hi);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            cq.push_back('{d, use_prog ? prog_ins(acc_pc) : rand_ins()});
        end
        model_step();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_logs();
        req_log.delete(); pop_pc_log.delete(); pop_pred_log.delete();
    endtask

    task automatic run_reqs(input int n, input string nm);
        int b = 0;
        while (req_log.size() < n && b < 60) begin cycle(); b++; end
        chk({nm, "_req_count"}, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic run_pops(input int n, input string nm);
        int b = 0;
        while (pop_pc_log.size() < n && b < 60) begin cycle(); b++; end
        chk({nm, "_pop_count"}, 32'(pop_pc_log.size() >= n), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] t);
        s_jp = 1; s_jpt = t;
        cycle();
        s_jp = 0;
        clear_logs();
    endtask

    initial begin
        int n0;
        s_rst = 1; s_rdy = 1; s_lsb = 0; s_rob = 0; s_rs = 0;
        s_br = 0; s_brt = 0; s_brpc = 32'h0; s_jp = 0; s_jpt = 32'h0;
        cycle();
        checks_on = 1'b1;
        run(2);
        s_rst = 0;
        #1;
        chk("rst_pc_cache", pc_cache, 32'h0);
        chk("rst_ins_flag", 32'(ins_flag), 32'd0);

        // 1: sequential ADDIs at latency 2
        clear_logs();
        run_pops(4, "t1");
        chk("t1_req0", req_log[0], 32'h0);  chk("t1_req1", req_log[1], 32'h4);
        chk("t1_req2", req_log[2], 32'h8);  chk("t1_req3", req_log[3], 32'hC);
        chk("t1_pop0", pop_pc_log[0], 32'h0); chk("t1_pop3", pop_pc_log[3], 32'hC);

        // 2: BEQ +0x20 at 0x10, untrained then trained
        prog[32'h10] = 32'h02000063;
        redirect(32'h10);
        run_reqs(2, "t2a");
        chk("t2_req0", req_log[0], 32'h10);
        chk("t2_req1_nt", req_log[1], 32'h14);
        run_pops(1, "t2a");
        chk("t2_pred_nt", 32'(pop_pred_log[0]), 32'd0);
        s_br = 1; s_brpc = 32'h10; s_brt = 1;
        run(2);
        s_br = 0;
        redirect(32'h10);
        run_reqs(2, "t2b");
        chk("t2_req1_t", req_log[1], 32'h30);
        run_pops(1, "t2b");
        chk("t2_pred_t", 32'(pop_pred_log[0]), 32'd1);

        // 3: JAL -0x40 at 0x40, JALR at 0x0 halts fetch
        prog[32'h40] = 32'hFC1FF06F;
        prog[32'h0]  = 32'h00008067;
        redirect(32'h40);
        run_reqs(2, "t3");
        chk("t3_jal_target", req_log[1], 32'h0);
        run_pops(2, "t3");
        chk("t3_jal_pred", 32'(pop_pred_log[0]), 32'd1);
        run(10);
        chk("t3_halt_reqs", 32'(req_log.size()), 32'd2);
        #1;
        chk("t3_halt_flag", 32'(pc_flag), 32'd0);
        redirect(32'h100);
        #1;
        chk("t3_redir_pc", pc_cache, 32'h100);
        run_reqs(1, "t3b");
        chk("t3_redir_req", req_log[0], 32'h100);

        // 4: backpressure fills the queue, release drains it
        s_rob = 1;
        redirect(32'h300);
        run(40);
        chk("t4_req_full", 32'(req_log.size()), 32'd8);
        #1;
        chk("t4_flag_full", 32'(pc_flag), 32'd0);
        chk("t4_ins_flag", 32'(ins_flag), 32'd1);
        s_rob = 0;
        run(30);
        chk("t4_pop0", pop_pc_log[0], 32'h300);
        chk("t4_pop7", pop_pc_log[7], 32'h31C);
        chk("t4_resumed", 32'(req_log.size() > 8), 32'd1);

        // 5: redirect while waiting, stale response arrives two cycles later
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20; i++) begin
            n0 = req_log.size();
            cycle();
            if (req_log.size() > n0) break;
        end
        redirect(32'h200);
        run_reqs(1, "t5");
        chk("t5_req0", req_log[0], 32'h200);
        run_pops(1, "t5");
        chk("t5_first_pop", pop_pc_log[0], 32'h200);

        // 6: redirect coinciding with a response and a pop, then rdy low
        lat_lo = 1; lat_hi = 1;
        s_rob = 1;
        run(10);
        s_rob = 0;
        arm6 = 1;
        for (int i = 0; i < 20 && !fired6; i++) cycle();
        arm6 = 0;
        chk("t6_fired", 32'(fired6), 32'd1);
        #1;
        chk("t6_ins_flag", 32'(ins_flag), 32'd0);
        chk("t6_pc", pc_cache, 32'h400);
        s_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1;
            chk("t6_frozen_pc", pc_cache, 32'h400);
            chk("t6_frozen_flag", 32'(pc_flag), 32'd0);
        end
        s_rdy = 1;
        run(5);

        // randomized phase
        use_prog = 0; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            s_rst = ($urandom_range(0, 399) == 0);
            s_rdy = ($urandom_range(0, 9) != 0);
            s_lsb = ($urandom_range(0, 5) == 0);
            s_rob = ($urandom_range(0, 5) == 0);
            s_rs  = ($urandom_range(0, 5) == 0);
            s_br  = ($urandom_range(0, 3) == 0);
            s_brpc = $urandom();
            s_brt = $urandom_range(0, 1);
            s_jp  = ($urandom_range(0, 24) == 0);
            s_jpt = {$urandom_range(0, 255), 2'b00};
            cycle();
        end
        s_rst = 0; s_rdy = 1; s_lsb = 0; s_rob = 0; s_rs = 0; s_br = 0; s_jp = 0;
        run(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
